// File: rtl/uart_pkg.sv
// Shared UART definitions: echo-responder FSM states and the ASCII constants
// used by the transmit-side upcase mapping.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } echo_state_e;

    localparam logic [7:0] AsciiLowerA     = 8'h61;
    localparam logic [7:0] AsciiLowerZ     = 8'h7A;
    localparam logic [7:0] AsciiCaseOffset = 8'h20;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered occupancy. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is reported on drop.
module fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AddrW = $clog2(Depth);
    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FullCount);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// Echoes every received UART word back through the transmitter via a FIFO,
// optionally upper-casing ASCII letters; dropped words are counted and flagged.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int WordLength = 8,
    parameter int FifoDepth  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WordLength-1:0] rx_data_i,
    input  logic                  rx_done_tick_i,
    input  logic                  tx_done_tick_i,
    input  logic                  upcase_i,
    output logic [WordLength-1:0] tx_data_o,
    output logic                  start_tx_o,
    output logic                  tx_busy_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o,
    output logic [7:0]            drop_cnt_o
);

    echo_state_e           state_q;
    echo_state_e           state_d;
    logic                  fifo_pop;
    logic                  fifo_drop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [WordLength-1:0] fifo_head;
    logic [WordLength-1:0] tx_word;
    logic [WordLength-1:0] tx_data_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;

    fifo_sync #(
        .Width (WordLength),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (rx_done_tick_i),
        .wdata  (rx_data_i),
        .pop    (fifo_pop),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    if (WordLength == 8) begin : g_upcase
        always_comb begin
            tx_word = fifo_head;
            if (upcase_i && (fifo_head >= AsciiLowerA) && (fifo_head <= AsciiLowerZ)) begin
                tx_word = fifo_head - AsciiCaseOffset;
            end
        end
    end else begin : g_plain
        assign tx_word = fifo_head;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START:     state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done_tick_i) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // start/busy are registered from the next state so they align with START.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= (state_d == START);
            busy_q  <= (state_d != IDLE);
            if (fifo_pop) begin
                tx_data_q <= tx_word;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    assign tx_data_o    = tx_data_q;
    assign start_tx_o   = start_q;
    assign tx_busy_o    = busy_q;
    assign fifo_empty_o = fifo_empty;
    assign fifo_full_o  = fifo_full;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule
